// File: rtl/temporizador_bcd.sv
// BCD M:SS countdown timer for the microwave controller: keypad entry, 1 Hz run, heater/beep.
// Optional +30 s key behaviour is compiled in when ADD30_EN is defined.
module temporizador_bcd #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  input  logic       add30,
  output logic [3:0] Minutes,
  output logic [3:0] TenSec,
  output logic [3:0] Sec,
  output logic       heater,
  output logic       beep
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_min;
  logic [3:0] r_ten;
  logic [3:0] r_sec;
  logic [3:0] r_dcnt;
  logic       r_heater;
  logic       r_beep;

  logic       w_zero;
  logic       w_last;
  logic       w_done_end;
  logic [3:0] w_nm;
  logic [3:0] w_nt;
  logic [3:0] w_ns;
  logic [3:0] w_dm;
  logic [3:0] w_dt;
  logic [3:0] w_ds;

  assign w_zero = (r_min == 4'd0) && (r_ten == 4'd0)
               && (r_sec == 4'd0);
  assign w_last = (r_min == 4'd0) && (r_ten == 4'd0)
               && (r_sec == 4'd1);
  assign w_done_end = (r_dcnt == 4'(DONE_TICKS - 1));

  // Entry may hold 60..99 s in the tens/units pair; fold it into minutes.
  always_comb begin
    w_nm = r_min;
    w_nt = r_ten;
    w_ns = r_sec;
    if (r_ten > 4'd5) begin
      if (r_min == 4'd9) begin
        w_nm = 4'd9;
        w_nt = 4'd5;
        w_ns = 4'd9;
      end else begin
        w_nm = r_min + 4'd1;
        w_nt = r_ten - 4'd6;
      end
    end
  end

  always_comb begin
    w_dm = r_min;
    w_dt = r_ten;
    w_ds = r_sec;
    if (r_sec != 4'd0) begin
      w_ds = r_sec - 4'd1;
    end else if (r_ten != 4'd0) begin
      w_dt = r_ten - 4'd1;
      w_ds = 4'd9;
    end else if (r_min != 4'd0) begin
      w_dm = r_min - 4'd1;
      w_dt = 4'd5;
      w_ds = 4'd9;
    end
  end

`ifdef ADD30_EN
  logic [3:0] w_am;
  logic [3:0] w_at;
  logic [3:0] w_as;

  // Operates on the normalized value, so tens digit is at most 5 here.
  always_comb begin
    w_am = w_nm;
    w_at = w_nt + 4'd3;
    w_as = w_ns;
    if (w_nt + 4'd3 > 4'd5) begin
      if (w_nm == 4'd9) begin
        w_am = 4'd9;
        w_at = 4'd5;
        w_as = 4'd9;
      end else begin
        w_am = w_nm + 4'd1;
        w_at = w_nt - 4'd3;
      end
    end
  end
`else
  logic w_unused_add30;
  assign w_unused_add30 = add30;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_min    <= 4'd0;
      r_ten    <= 4'd0;
      r_sec    <= 4'd0;
      r_dcnt   <= 4'd0;
      r_heater <= 1'b0;
      r_beep   <= 1'b0;
    end else begin
      // Heater trails the state by one clock.
      r_heater <= (r_state == S_RUN);
      unique case (r_state)
        S_IDLE: begin
          if (stop) begin
            r_min <= 4'd0;
            r_ten <= 4'd0;
            r_sec <= 4'd0;
          end else if (start) begin
            if (!door_open && !w_zero) begin
              r_min   <= w_nm;
              r_ten   <= w_nt;
              r_sec   <= w_ns;
              r_state <= S_RUN;
            end
          end
`ifdef ADD30_EN
          else if (add30) begin
            if (!door_open) begin
              r_min   <= w_am;
              r_ten   <= w_at;
              r_sec   <= w_as;
              r_state <= S_RUN;
            end
          end
`endif
          else if (key_valid && (key_digit <= 4'd9)) begin
            r_min <= r_ten;
            r_ten <= r_sec;
            r_sec <= key_digit;
          end
        end
        S_RUN: begin
          if (door_open || stop) begin
            r_state <= S_PAUSE;
          end
`ifdef ADD30_EN
          else if (add30) begin
            r_min <= w_am;
            r_ten <= w_at;
            r_sec <= w_as;
          end
`endif
          else if (tick_1hz) begin
            r_min <= w_dm;
            r_ten <= w_dt;
            r_sec <= w_ds;
            if (w_last) begin
              r_state <= S_DONE;
              r_dcnt  <= 4'd0;
              r_beep  <= 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            r_min   <= 4'd0;
            r_ten   <= 4'd0;
            r_sec   <= 4'd0;
            r_state <= S_IDLE;
          end else if (start) begin
            if (!door_open) begin
              r_state <= S_RUN;
            end
          end
`ifdef ADD30_EN
          else if (add30) begin
            r_min <= w_am;
            r_ten <= w_at;
            r_sec <= w_as;
          end
`endif
        end
        S_DONE: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_beep  <= 1'b0;
          end else if (tick_1hz) begin
            if (w_done_end) begin
              r_state <= S_IDLE;
              r_beep  <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign Minutes = r_min;
  assign TenSec  = r_ten;
  assign Sec     = r_sec;
  assign heater  = r_heater;
  assign beep    = r_beep;

endmodule

// File: tb/tb_temporizador_bcd.sv
// Scoreboard bench for temporizador_bcd: seconds-based reference model,
// directed scenarios followed by randomized keypad/tick/door traffic.
module tb_temporizador_bcd;

  localparam int DT = 3;
`ifdef ADD30_EN
  localparam bit ADD30 = 1'b1;
`else
  localparam bit ADD30 = 1'b0;
`endif
  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  localparam int MD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_open = 1'b0;
  logic       add30 = 1'b0;
  logic [3:0] Minutes;
  logic [3:0] TenSec;
  logic [3:0] Sec;
  logic       heater;
  logic       beep;

  temporizador_bcd #(.DONE_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_open(door_open),
    .add30(add30), .Minutes(Minutes), .TenSec(TenSec),
    .Sec(Sec), .heater(heater), .beep(beep)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [13:0] exp_q[$];

  bit door = 1'b0;
  bit rstv = 1'b0;

  // Reference model: entry digits while idle, plain seconds while timing.
  int md[3];
  int mt;
  int mst;
  int mcnt;
  bit mh;
  bit mb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int sat(input int x);
    return (x > 599) ? 599 : x;
  endfunction

  function automatic int entry_secs();
    return md[0] * 60 + md[1] * 10 + md[2];
  endfunction

  function automatic void model_reset();
    md = '{0, 0, 0};
    mt = 0; mst = MI; mcnt = 0; mh = 0; mb = 0;
  endfunction

  function automatic void model_step(input bit kv, input int kd,
    input bit st, input bit sp, input bit dr, input bit tk, input bit a3);
    bit was_run;
    was_run = (mst == MR);
    case (mst)
      MI: begin
        if (sp) md = '{0, 0, 0};
        else if (st) begin
          if (!dr && entry_secs() != 0) begin
            mt = sat(entry_secs()); mst = MR;
          end
        end else if (a3 && ADD30) begin
          if (!dr) begin
            mt = sat(sat(entry_secs()) + 30); mst = MR;
          end
        end else if (kv && kd <= 9) begin
          md[0] = md[1]; md[1] = md[2]; md[2] = kd;
        end
      end
      MR: begin
        if (dr || sp) mst = MP;
        else if (a3 && ADD30) mt = sat(mt + 30);
        else if (tk) begin
          mt = mt - 1;
          if (mt == 0) begin
            mst = MD; mcnt = 0; md = '{0, 0, 0};
          end
        end
      end
      MP: begin
        if (sp) begin
          mst = MI; md = '{0, 0, 0};
        end else if (st) begin
          if (!dr) mst = MR;
        end else if (a3 && ADD30) mt = sat(mt + 30);
      end
      default: begin
        if (sp) mst = MI;
        else if (tk) begin
          mcnt++;
          if (mcnt == DT) mst = MI;
        end
      end
    endcase
    mh = was_run;
    mb = (mst == MD);
  endfunction

  function automatic logic [13:0] mout();
    int a, b, c;
    if (mst == MR || mst == MP) begin
      a = mt / 60; b = (mt % 60) / 10; c = mt % 10;
    end else begin
      a = md[0]; b = md[1]; c = md[2];
    end
    return {a[3:0], b[3:0], c[3:0], mh, mb};
  endfunction

  task automatic step(input bit kv, input int kd, input bit st,
                      input bit sp, input bit tk, input bit a3);
    @(negedge clk);
    rst_n = rstv;
    key_valid = kv;
    key_digit = kd[3:0];
    start = st;
    stop = sp;
    door_open = door;
    tick_1hz = tk;
    add30 = a3;
    if (!rstv) model_reset();
    else model_step(kv, kd, st, sp, door, tk, a3);
    exp_q.push_back(mout());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic key(input int d);
    step(1, d, 0, 0, 0, 0);
  endtask
  task automatic go();
    step(0, 0, 1, 0, 0, 0);
  endtask
  task automatic halt();
    step(0, 0, 0, 1, 0, 0);
  endtask
  task automatic tick();
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic chk_now(input string nm, input int m, input int t,
                         input int s, input bit h, input bit b);
    logic [13:0] e;
    e = {m[3:0], t[3:0], s[3:0], h, b};
    @(posedge clk);
    #2;
    chk(nm, {Minutes, TenSec, Sec, heater, beep}, e);
  endtask

  always @(posedge clk) begin : monitor
    logic [13:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", {Minutes, TenSec, Sec, heater, beep}, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rstv = 0;
    repeat (2) idle();
    chk_now("reset_state", 0, 0, 0, 0, 0);
    rstv = 1;
    idle();

    key(1); key(3); key(0); go();
    chk_now("start_130", 1, 3, 0, 0, 0);
    tick(); idle(); tick(); tick();
    chk_now("run_127", 1, 2, 7, 1, 0);
    key(5);
    halt(); halt();
    chk_now("cancel_000", 0, 0, 0, 0, 0);

    key(9); key(0); go();
    chk_now("norm_90", 1, 3, 0, 0, 0);
    halt(); halt();
    key(9); key(9); key(9); go();
    chk_now("sat_959", 9, 5, 9, 0, 0);
    halt(); halt();
    key(9); key(9); go();
    chk_now("norm_99", 1, 3, 9, 0, 0);
    halt(); halt();
    key(12); key(7);
    chk_now("key_gt9", 0, 0, 7, 0, 0);
    halt();
    go();
    chk_now("start_zero", 0, 0, 0, 0, 0);

    key(2); go(); idle(); tick(); tick();
    chk_now("done_entry", 0, 0, 0, 1, 1);
    tick(); tick();
    chk_now("done_beep", 0, 0, 0, 0, 1);
    tick();
    chk_now("done_exit", 0, 0, 0, 0, 0);

    key(4); key(5); go(); idle();
    door = 1;
    tick();
    chk_now("door_pause", 0, 4, 5, 1, 0);
    go(); tick();
    chk_now("open_start", 0, 4, 5, 0, 0);
    door = 0;
    go(); tick();
    chk_now("resume", 0, 4, 4, 1, 0);
    halt(); halt();
    chk_now("stop_stop", 0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 0, 1);
`ifdef ADD30_EN
    chk_now("add30_idle", 0, 3, 0, 0, 0);
`else
    chk_now("add30_idle", 0, 0, 0, 0, 0);
`endif
    halt(); halt(); halt();

    key(1); key(2); key(3); go(); idle();
    @(negedge clk);
    rst_n = 0;
    rstv = 0;
    #1;
    chk("async_rst", {Minutes, TenSec, Sec, heater, beep}, 14'd0);
    model_reset();
    exp_q.push_back(mout());
    idle();
    rstv = 1;
    idle();

    for (int i = 0; i < 4000; i++) begin
      bit kv, st, sp, tk, a3;
      int kd;
      if ($urandom_range(99) < 4) door = ~door;
      rstv = ($urandom_range(999) != 0);
      kv = ($urandom_range(99) < 20);
      kd = $urandom_range(15);
      st = ($urandom_range(99) < 8);
      sp = ($urandom_range(99) < 3);
      tk = ($urandom_range(99) < 30);
      a3 = ($urandom_range(99) < 5);
      step(kv, kd, st, sp, tk, a3);
    end
    rstv = 1;
    door = 0;
    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
